// File: rtl/axis_word_unpacker_if.sv
// Handshake bundle for the word unpacker: wide word in, byte stream out.
// slave = unpacker side, master = the environment driving and consuming it.
interface axis_word_unpacker_if #(
    parameter int nb = 40
);
    logic [nb-1:0] in_tdata;
    logic          in_tvalid;
    logic          in_tready;
    logic [7:0]    out_tdata;
    logic          out_tvalid;
    logic          out_tready;
    logic          out_tlast;

    modport slave (
        input  in_tdata, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tvalid, out_tlast
    );

    modport master (
        output in_tdata, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tvalid, out_tlast
    );
endinterface

// File: rtl/axis_word_unpacker.sv
// Splits one nb-bit word into n byte beats, tlast on the final byte; first byte valid the cycle after accept.
// Stalled outputs hold stable; a new word is taken in the same cycle the last byte leaves, so no bubbles.
module axis_word_unpacker #(
    parameter int n         = 5,
    parameter int nb        = n * 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axis_word_unpacker_if.slave  bus
);
    localparam int             IW   = (n > 1) ? $clog2(n) : 1;
    localparam logic [IW-1:0]  LAST = IW'(n - 1);

    logic [nb-1:0]       word_q, word_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                full_q, full_d;

    logic                last;
    logic                in_rdy;
    logic                in_acc;
    logic                out_acc;
    logic [IW-1:0]       sel;
    logic [n-1:0][7:0]   word_bytes;

    assign last       = (idx_q == LAST);
    assign word_bytes = word_q;

    // state register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            full_q <= full_d;
        end
    end

    // next state
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        full_d  = full_q;
        in_acc  = bus.in_tvalid & in_rdy;
        out_acc = full_q & bus.out_tready;
        if (!full_q) begin
            if (in_acc) begin
                word_d = bus.in_tdata;
                idx_d  = '0;
                full_d = 1'b1;
            end
        end else if (out_acc) begin
            if (!last) begin
                idx_d = idx_q + IW'(1);
            end else if (in_acc) begin
                // last byte leaves and the next word lands in the same edge
                word_d = bus.in_tdata;
                idx_d  = '0;
            end else begin
                full_d = 1'b0;
                idx_d  = '0;
            end
        end
    end

    // outputs: only in_tready sees a combinational input (out_tready)
    always_comb begin
        in_rdy         = aresetn & (~full_q | (bus.out_tready & last));
        sel            = MSB_FIRST ? (LAST - idx_q) : idx_q;
        bus.in_tready  = in_rdy;
        bus.out_tvalid = full_q;
        bus.out_tlast  = full_q & last;
        bus.out_tdata  = word_bytes[sel];
    end
endmodule

// File: tb/tb_axis_word_unpacker.sv
// Bench for axis_word_unpacker: MSB-first and LSB-first instances share one stimulus,
// a queue-based byte model checks every cycle, and literal byte lists pin the model.
module tb_axis_word_unpacker;
    localparam int N  = 5;
    localparam int NB = 40;

    typedef struct {
        logic [7:0] d;
        logic       l;
        int         c;
    } beat_t;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [NB-1:0] in_tdata;
    logic          in_tvalid;
    logic          out_tready;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    bit    chk_en  = 1'b0;
    beat_t mq[2][$];
    beat_t got[2][$];
    logic [7:0] exp_q[$];

    axis_word_unpacker_if #(.nb(NB)) if0 ();
    axis_word_unpacker_if #(.nb(NB)) if1 ();

    assign if0.in_tdata   = in_tdata;
    assign if0.in_tvalid  = in_tvalid;
    assign if0.out_tready = out_tready;
    assign if1.in_tdata   = in_tdata;
    assign if1.in_tvalid  = in_tvalid;
    assign if1.out_tready = out_tready;

    axis_word_unpacker #(.n(N), .nb(NB), .MSB_FIRST(1'b1)) u0 (.aclk(clk), .aresetn(aresetn), .bus(if0));
    axis_word_unpacker #(.n(N), .nb(NB), .MSB_FIRST(1'b0)) u1 (.aclk(clk), .aresetn(aresetn), .bus(if1));

    logic [1:0] rdy_s, vld_s, lst_s;
    logic [7:0] dat_s[2];
    assign rdy_s    = {if1.in_tready, if0.in_tready};
    assign vld_s    = {if1.out_tvalid, if0.out_tvalid};
    assign lst_s    = {if1.out_tlast, if0.out_tlast};
    assign dat_s[0] = if0.out_tdata;
    assign dat_s[1] = if1.out_tdata;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a word becomes n queued bytes; the consumer pops one per accepted beat.
    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!aresetn) begin
                mq[k].delete();
            end else begin
                bit er;
                er = (mq[k].size() == 0) || (out_tready && mq[k].size() == 1);
                if (mq[k].size() > 0 && out_tready) void'(mq[k].pop_front());
                if (in_tvalid && er) begin
                    for (int i = 0; i < N; i++) begin
                        beat_t b;
                        int    bi;
                        bi  = (k == 0) ? (N - 1 - i) : i;
                        b.d = in_tdata[8*bi +: 8];
                        b.l = (i == N - 1);
                        b.c = 0;
                        mq[k].push_back(b);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic er;
                er = aresetn && (mq[k].size() == 0 || (out_tready && mq[k].size() == 1));
                chk($sformatf("in_tready[%0d]", k), 64'(rdy_s[k]), 64'(er));
                chk($sformatf("out_tvalid[%0d]", k), 64'(vld_s[k]), 64'(mq[k].size() > 0));
                if (mq[k].size() > 0) begin
                    chk($sformatf("out_tdata[%0d]", k), 64'(dat_s[k]), 64'(mq[k][0].d));
                    chk($sformatf("out_tlast[%0d]", k), 64'(lst_s[k]), 64'(mq[k][0].l));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (aresetn) begin
            for (int k = 0; k < 2; k++)
                if (vld_s[k] && out_tready) got[k].push_back('{dat_s[k], lst_s[k], cyc});
        end
    end

    task automatic wait_rdy();
        int t;
        t = 0;
        #1;
        while (!rdy_s[0] && t < 40) begin
            @(posedge clk);
            #2;
            t++;
        end
        if (!rdy_s[0]) chk("in_tready_timeout", 64'(rdy_s[0]), 64'd1);
    endtask

    task automatic send(input logic [NB-1:0] w);
        in_tdata  = w;
        in_tvalid = 1'b1;
        wait_rdy();
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((mq[0].size() > 0 || mq[1].size() > 0) && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", 64'(mq[0].size() + mq[1].size()), 64'd0);
        chk("idle_tvalid", 64'(vld_s), 64'd0);
    endtask

    task automatic wait_byte(input logic [7:0] b);
        int t;
        t = 0;
        while (dat_s[0] !== b && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("wait_byte", 64'(dat_s[0]), 64'(b));
    endtask

    // compares collected beats of instance k with exp_q; tlast every N-th byte
    task automatic chk_got(input int k, input string nm, input bit contig);
        chk({nm, "_count"}, 64'(got[k].size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got[k].size(); i++) begin
            chk($sformatf("%s_byte%0d", nm, i), 64'(got[k][i].d), 64'(exp_q[i]));
            chk($sformatf("%s_last%0d", nm, i), 64'(got[k][i].l), 64'((i % N) == N - 1));
            if (contig)
                chk($sformatf("%s_cyc%0d", nm, i), 64'(got[k][i].c - got[k][0].c), 64'(i));
        end
    endtask

    task automatic clear_got();
        got[0].delete();
        got[1].delete();
    endtask

    initial begin
        // T1: reset held with in_tvalid high
        aresetn    = 1'b0;
        in_tvalid  = 1'b1;
        in_tdata   = 40'hDEADBEEF01;
        out_tready = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid0", 64'(if0.out_tvalid), 64'd0);
        chk("rst_tready0", 64'(if0.in_tready), 64'd0);
        chk("rst_tdata0", 64'(if0.out_tdata), 64'h00);
        chk("rst_tdata1", 64'(if1.out_tdata), 64'h00);
        in_tvalid = 1'b0;
        aresetn   = 1'b1;
        @(posedge clk);
        #1;

        // T2 / T5: single word, MSB-first and LSB-first views
        clear_got();
        send(40'h1122334455);
        chk("t2_first_byte", 64'(if0.out_tdata), 64'h11);
        drain();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        chk_got(0, "t2", 1'b1);
        exp_q = '{8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        chk_got(1, "t5", 1'b1);

        // T3: back-to-back words with no gap
        clear_got();
        in_tdata  = 40'hA1A2A3A4A5;
        in_tvalid = 1'b1;
        wait_rdy();
        @(posedge clk);
        #1;
        in_tdata = 40'hB1B2B3B4B5;
        wait_rdy();
        chk("t3_rdy_on_a5", 64'(if0.out_tdata), 64'hA5);
        chk("t3_rdy_tlast", 64'(if0.out_tlast), 64'd1);
        chk("t3_rdy_lsb_a1", 64'(if1.out_tdata), 64'hA1);
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        drain();
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        chk_got(0, "t3", 1'b1);

        // T4: stall three clocks while 33 is shown
        clear_got();
        send(40'h1122334455);
        wait_byte(8'h33);
        out_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            chk("t4_hold_data", 64'(if0.out_tdata), 64'h33);
            chk("t4_hold_vld", 64'(if0.out_tvalid), 64'd1);
            chk("t4_hold_rdy", 64'(if0.in_tready), 64'd0);
        end
        out_tready = 1'b1;
        drain();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        chk_got(0, "t4", 1'b0);

        // T6: reset after byte 22 leaves, then a fresh word
        clear_got();
        send(40'h1122334455);
        wait_byte(8'h33);
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_rst_vld0", 64'(if0.out_tvalid), 64'd0);
        chk("t6_rst_dat0", 64'(if0.out_tdata), 64'h00);
        aresetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_post_vld", 64'(vld_s), 64'd0);
        exp_q = '{8'h11, 8'h22};
        chk_got(0, "t6_pre", 1'b1);
        clear_got();
        send(40'hC1C2C3C4C5);
        drain();
        exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        chk_got(0, "t6_msb", 1'b1);
        exp_q = '{8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1};
        chk_got(1, "t6_lsb", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
